// File: rtl/gpr_scoreboard_file_pkg.sv
// Shared constants and helpers for the GPR scoreboard file.
// Holds the default register width/depth and port counts, the default overflow
// register index, and the helper that locates port i inside a packed bus.
package gpr_scoreboard_file_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 5;
  localparam int DEF_NRD     = 2;
  localparam int DEF_NWR     = 2;
  localparam int DEF_OVF_REG = 30;

  // Low bit of port `port` in a bus built from `width`-bit fields.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/gpr_scoreboard_file_if.sv
// Bus bundle for the GPR scoreboard file: read ports, write ports, the issue
// port and the scoreboard/overflow status outputs.
//   master : drives rd_addr, wr_*, iss_*; observes rd_*, busy_vec, ovf_pulse
//   slave  : the register file itself
interface gpr_scoreboard_file_if
  import gpr_scoreboard_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD,
  parameter int NWR    = DEF_NWR
);
  localparam int NREG = 2 ** ADDR_W;

  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_neg;
  logic [NRD-1:0]        rd_busy;

  logic [NWR-1:0]        wr_en;
  logic [NWR-1:0]        wr_ovf;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;

  logic                  iss_valid;
  logic [ADDR_W-1:0]     iss_addr;

  logic [NREG-1:0]       busy_vec;
  logic                  ovf_pulse;

  modport master (
    output rd_addr, wr_en, wr_ovf, wr_addr, wr_data, iss_valid, iss_addr,
    input  rd_data, rd_neg, rd_busy, busy_vec, ovf_pulse
  );

  modport slave (
    input  rd_addr, wr_en, wr_ovf, wr_addr, wr_data, iss_valid, iss_addr,
    output rd_data, rd_neg, rd_busy, busy_vec, ovf_pulse
  );

endinterface

// File: rtl/gpr_scoreboard_file_wr_arbiter.sv
// gpr_wr_arbiter: resolves same-cycle writes per register.
// Ports:
//   wr_en/wr_ovf/wr_addr/wr_data : raw write ports (higher index wins)
//   hit      : some port presented wr_en to this register (clears busy)
//   upd      : winning port is a normal write, so the register takes upd_data
//   upd_data : winning write data per register
//   ovf_any  : at least one port presented an overflowed write to a nonzero index
module gpr_wr_arbiter
  import gpr_scoreboard_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NWR    = DEF_NWR,
  localparam int NREG  = 2 ** ADDR_W
) (
  input  logic [NWR-1:0]                  wr_en,
  input  logic [NWR-1:0]                  wr_ovf,
  input  logic [NWR*ADDR_W-1:0]           wr_addr,
  input  logic [NWR*DATA_W-1:0]           wr_data,
  output logic [NREG-1:0]                 hit,
  output logic [NREG-1:0]                 upd,
  output logic [NREG-1:0][DATA_W-1:0]     upd_data,
  output logic                            ovf_any
);

  logic [ADDR_W-1:0] a;

  // Ascending scan: a later (higher-index) port overwrites an earlier one, so an
  // overflowed winner also cancels a lower port's normal write to that index.
  // Overflow marks from every port count, even when that port lost its address.
  always_comb begin
    hit      = '0;
    upd      = '0;
    upd_data = '0;
    ovf_any  = 1'b0;
    a        = '0;
    for (int p = 0; p < NWR; p++) begin
      a = wr_addr[slice_lo(p, ADDR_W) +: ADDR_W];
      if (wr_en[p] && a != '0) begin
        hit[a]      = 1'b1;
        upd[a]      = !wr_ovf[p];
        upd_data[a] = wr_data[slice_lo(p, DATA_W) +: DATA_W];
        if (wr_ovf[p]) ovf_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpr_scoreboard_file.sv
// gpr_scoreboard_file: multi-ported register file with a pending-write
// scoreboard and an overflow sticky bit in OVF_REG.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave side of gpr_scoreboard_file_if (reads, writes, issue, status)
// With BYPASS=1 reads see the next-state value (same-cycle write forwarding).
module gpr_scoreboard_file
  import gpr_scoreboard_file_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NRD     = DEF_NRD,
  parameter int NWR     = DEF_NWR,
  parameter int BYPASS  = 1,
  parameter int OVF_REG = DEF_OVF_REG
) (
  input logic              clk,
  input logic              reset,
  gpr_scoreboard_file_if.slave bus
);

  localparam int NREG = 2 ** ADDR_W;

  logic [NREG-1:0][DATA_W-1:0] regs, regs_nxt, upd_data;
  logic [NREG-1:0]             busy, busy_nxt, hit, upd;
  logic                        ovf_any, ovf_q;

  gpr_wr_arbiter #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .NWR    (NWR)
  ) u_arb (
    .wr_en    (bus.wr_en),
    .wr_ovf   (bus.wr_ovf),
    .wr_addr  (bus.wr_addr),
    .wr_data  (bus.wr_data),
    .hit      (hit),
    .upd      (upd),
    .upd_data (upd_data),
    .ovf_any  (ovf_any)
  );

  always_comb begin
    regs_nxt = regs;
    for (int r = 1; r < NREG; r++) begin
      if (upd[r]) regs_nxt[r] = upd_data[r];
    end
    // Overflow mark merges into whatever OVF_REG receives this cycle.
    if (ovf_any && OVF_REG != 0) regs_nxt[OVF_REG][0] = 1'b1;
    regs_nxt[0] = '0;

    // Issue is applied after the write clear: a new producer keeps it busy.
    busy_nxt = busy & ~hit;
    if (bus.iss_valid) busy_nxt[bus.iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs  <= '0;
      busy  <= '0;
      ovf_q <= 1'b0;
    end else begin
      regs  <= regs_nxt;
      busy  <= busy_nxt;
      ovf_q <= ovf_any;
    end
  end

  assign bus.busy_vec  = busy;
  assign bus.ovf_pulse = ovf_q;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rw;
    assign ra = bus.rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
    assign rw = (BYPASS != 0) ? regs_nxt[ra] : regs[ra];
    assign bus.rd_data[slice_lo(i, DATA_W) +: DATA_W] = rw;
    assign bus.rd_neg[i]  = rw[DATA_W-1];
    assign bus.rd_busy[i] = (BYPASS != 0) ? busy_nxt[ra] : busy[ra];
  end

endmodule

// File: tb/tb_gpr_scoreboard_file.sv
// Self-checking bench for gpr_scoreboard_file: one BYPASS=1 and one BYPASS=0
// instance share stimulus; an array-based reference model predicts both.
module tb_gpr_scoreboard_file;
  import gpr_scoreboard_file_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gpr_scoreboard_file_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .NWR(2)) b0 ();
  gpr_scoreboard_file_if #(.DATA_W(DW), .ADDR_W(AW), .NRD(2), .NWR(2)) b1 ();

  gpr_scoreboard_file #(.BYPASS(1)) dut_byp (.clk(clk), .reset(reset), .bus(b0));
  gpr_scoreboard_file #(.BYPASS(0)) dut_reg (.clk(clk), .reset(reset), .bus(b1));

  assign b1.rd_addr   = b0.rd_addr;
  assign b1.wr_en     = b0.wr_en;
  assign b1.wr_ovf    = b0.wr_ovf;
  assign b1.wr_addr   = b0.wr_addr;
  assign b1.wr_data   = b0.wr_data;
  assign b1.iss_valid = b0.iss_valid;
  assign b1.iss_addr  = b0.iss_addr;

  // stimulus in unpacked form
  bit          s_en[2], s_ovf[2];
  int unsigned s_addr[2], s_data[2], s_rd[2];
  bit          s_iss;
  int unsigned s_iss_addr;

  // reference model: current and next state
  int unsigned mreg[NR], nreg[NR];
  bit          mbusy[NR], nbusy[NR];
  bit          mpulse, npulse;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int p = 0; p < 2; p++) begin
      s_en[p] = 0; s_ovf[p] = 0; s_addr[p] = 0; s_data[p] = 0;
    end
    s_iss = 0; s_iss_addr = 0;
  endtask

  task automatic wr(input int p, input int unsigned a, input int unsigned d, input bit o);
    s_en[p] = 1; s_addr[p] = a; s_data[p] = d; s_ovf[p] = o;
  endtask

  task automatic iss(input int unsigned a);
    s_iss = 1; s_iss_addr = a;
  endtask

  task automatic apply();
    for (int p = 0; p < 2; p++) begin
      b0.wr_en[p]                = s_en[p];
      b0.wr_ovf[p]               = s_ovf[p];
      b0.wr_addr[p*AW +: AW]     = s_addr[p][AW-1:0];
      b0.wr_data[p*DW +: DW]     = s_data[p];
      b0.rd_addr[p*AW +: AW]     = s_rd[p][AW-1:0];
    end
    b0.iss_valid = s_iss;
    b0.iss_addr  = s_iss_addr[AW-1:0];
  endtask

  // Next state from the rules: highest port writing a register decides it;
  // an overflowed winner leaves it alone; any overflow marks bit 0 of r30.
  function automatic void model_next();
    nreg = mreg; nbusy = mbusy; npulse = 0;
    for (int r = 1; r < NR; r++) begin
      for (int p = 1; p >= 0; p--) begin
        if (s_en[p] && s_addr[p] == r) begin
          if (!s_ovf[p]) nreg[r] = s_data[p];
          nbusy[r] = 0;
          break;
        end
      end
      if (s_iss && s_iss_addr == r) nbusy[r] = 1;
    end
    for (int p = 0; p < 2; p++)
      if (s_en[p] && s_ovf[p] && s_addr[p] != 0) npulse = 1;
    if (npulse) nreg[30] = nreg[30] | 1;
  endfunction

  function automatic logic [31:0] pack_busy();
    logic [31:0] v;
    for (int r = 0; r < NR; r++) v[r] = mbusy[r];
    return v;
  endfunction

  task automatic settle();
    logic [31:0] eb, er;
    apply();
    model_next();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      eb = nreg[s_rd[i]];
      er = mreg[s_rd[i]];
      chk($sformatf("byp_rd_data%0d", i), b0.rd_data[i*DW +: DW], eb);
      chk($sformatf("byp_rd_neg%0d", i),  b0.rd_neg[i], eb[31]);
      chk($sformatf("byp_rd_busy%0d", i), b0.rd_busy[i], nbusy[s_rd[i]]);
      chk($sformatf("reg_rd_data%0d", i), b1.rd_data[i*DW +: DW], er);
      chk($sformatf("reg_rd_neg%0d", i),  b1.rd_neg[i], er[31]);
      chk($sformatf("reg_rd_busy%0d", i), b1.rd_busy[i], mbusy[s_rd[i]]);
    end
    chk("byp_busy_vec", b0.busy_vec, pack_busy());
    chk("reg_busy_vec", b1.busy_vec, pack_busy());
    chk("byp_ovf_pulse", b0.ovf_pulse, mpulse);
    chk("reg_ovf_pulse", b1.ovf_pulse, mpulse);
  endtask

  task automatic commit();
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < NR; r++) begin mreg[r] = 0; mbusy[r] = 0; end
      mpulse = 0;
    end else begin
      mreg = nreg; mbusy = nbusy; mpulse = npulse;
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    commit();
  endtask

  initial begin
    int unsigned pick[7] = '{0, 1, 2, 3, 7, 30, 31};
    reset = 1;
    clear_stim();
    s_rd[0] = 0; s_rd[1] = 0;
    apply();
    repeat (2) @(posedge clk);
    #1;
    for (int r = 0; r < NR; r++) begin mreg[r] = 0; mbusy[r] = 0; end
    mpulse = 0;

    // reset state
    settle();
    chk("rst_busy_vec", b0.busy_vec, 0);
    chk("rst_ovf_pulse", b0.ovf_pulse, 0);
    commit();
    reset = 0;

    // write r5, read back next cycle
    clear_stim(); wr(0, 5, 32'hDEADBEEF, 0); cyc();
    clear_stim(); s_rd[0] = 5; settle();
    chk("r5_data", b1.rd_data[DW-1:0], 32'hDEADBEEF);
    chk("r5_neg", b1.rd_neg[0], 1);
    commit();

    // both ports write r7
    clear_stim(); wr(0, 7, 1, 0); wr(1, 7, 2, 0); s_rd[0] = 7; settle();
    chk("r7_bypass", b0.rd_data[DW-1:0], 2);
    commit();
    clear_stim(); s_rd[1] = 7; settle();
    chk("r7_stored", b1.rd_data[2*DW-1:DW], 2);
    commit();

    // overflow mark into r30
    clear_stim(); wr(0, 30, 32'h10, 0); wr(1, 9, 32'h55, 0); cyc();
    clear_stim(); wr(1, 9, 32'hAAAA, 1); cyc();
    clear_stim(); s_rd[0] = 9; s_rd[1] = 30; settle();
    chk("r9_unchanged", b1.rd_data[DW-1:0], 32'h55);
    chk("r30_marked", b1.rd_data[2*DW-1:DW], 32'h11);
    chk("ovf_pulse_hi", b0.ovf_pulse, 1);
    commit();
    settle();
    chk("ovf_pulse_lo", b0.ovf_pulse, 0);
    commit();

    // same-edge normal write to r30 plus overflow mark elsewhere
    clear_stim(); wr(0, 30, 32'h100, 0); wr(1, 3, 32'h9, 1); s_rd[0] = 30; settle();
    chk("r30_merge_byp", b0.rd_data[DW-1:0], 32'h101);
    commit();

    // scoreboard: issue r4, idle, write+issue, plain write
    clear_stim(); s_rd[0] = 4; s_rd[1] = 0; iss(4); cyc();
    for (int k = 0; k < 3; k++) begin
      clear_stim(); settle();
      chk("r4_busy_idle", b1.rd_busy[0], 1);
      commit();
    end
    clear_stim(); wr(0, 4, 32'h44, 0); iss(4); settle();
    chk("r4_busy_reissue", b0.rd_busy[0], 1);
    commit();
    clear_stim(); settle();
    chk("r4_busy_kept", b1.rd_busy[0], 1);
    commit();
    clear_stim(); wr(1, 4, 32'h45, 0); settle();
    chk("r4_busy_clr_byp", b0.rd_busy[0], 0);
    commit();
    clear_stim(); settle();
    chk("r4_busy_clr", b1.rd_busy[0], 0);
    commit();

    // register 0 is immutable
    clear_stim(); wr(0, 0, 32'hFFFFFFFF, 0); iss(0); cyc();
    clear_stim(); s_rd[0] = 0; settle();
    chk("r0_data", b1.rd_data[DW-1:0], 0);
    chk("r0_busy", b1.busy_vec[0], 0);
    commit();

    // reset mid-sequence
    clear_stim(); iss(3); wr(1, 3, 32'h33, 0); cyc();
    clear_stim(); reset = 1; wr(0, 8, 32'h8, 1); iss(6); cyc();
    reset = 0;
    clear_stim(); s_rd[0] = 3; settle();
    chk("rst_r3", b1.rd_data[DW-1:0], 0);
    chk("rst_busy_all", b1.busy_vec, 0);
    chk("rst_ovf", b1.ovf_pulse, 0);
    commit();

    // randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      clear_stim();
      for (int p = 0; p < 2; p++) begin
        s_en[p]   = ($urandom_range(0, 2) != 0);
        s_ovf[p]  = ($urandom_range(0, 4) == 0);
        s_addr[p] = pick[$urandom_range(0, 6)];
        s_data[p] = $urandom;
        s_rd[p]   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : pick[$urandom_range(0, 6)];
      end
      s_iss      = $urandom_range(0, 1);
      s_iss_addr = pick[$urandom_range(0, 6)];
      reset      = ($urandom_range(0, 49) == 0);
      cyc();
    end
    reset = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_scoreboard_file.md
GPR_SCOREBOARD_FILE -- requirements
Module: gpr_scoreboard_file

Interface
REQ-001 Parameter DATA_W, 32, register width in bits.
REQ-002 Parameter ADDR_W, 5, register index width; NREG = 2**ADDR_W registers.
REQ-003 Parameter NRD, 2, number of read ports.
REQ-004 Parameter NWR, 2, number of write ports; port NWR-1 has highest priority.
REQ-005 Parameter BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads show registered state only.
REQ-006 Parameter OVF_REG, 30, register whose bit 0 is set on an overflowed write.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 reset  input  1  synchronous, active-high reset; takes effect only at a rising clk edge.
REQ-009 rd_addr  input  NRD*ADDR_W  read indices; port i at slice [i*ADDR_W +: ADDR_W].
REQ-010 rd_data  output  NRD*DATA_W  read data, combinational from rd_addr.
REQ-011 rd_neg  output  NRD  per-port sign bit: MSB of rd_data of that port.
REQ-012 rd_busy  output  NRD  per-port scoreboard busy bit of the addressed register.
REQ-013 wr_en / wr_ovf  input  NWR each  write strobe and overflow flag per write port.
REQ-014 wr_addr / wr_data  input  NWR*ADDR_W / NWR*DATA_W  write index and data per port.
REQ-015 iss_valid / iss_addr  input  1 / ADDR_W  issue port: marks a destination register pending.
REQ-016 busy_vec  output  NREG  full scoreboard, registered.
REQ-017 ovf_pulse  output  1  registered; high for one cycle after any accepted overflowed write.

Function
REQ-018 Register 0 SHALL always read 0; writes, overflow marks and issues targeting index 0 SHALL be ignored.
REQ-019 An accepted write (wr_en=1, wr_ovf=0, addr!=0) SHALL update the register at the next rising edge.
REQ-020 wr_en=1 with wr_ovf=1 SHALL leave the destination unchanged and set OVF_REG bit 0 at the next edge; other OVF_REG bits are held.
REQ-021 On the same edge, a normal write to OVF_REG and an overflow mark SHALL combine: written data with bit 0 forced to 1.
REQ-022 When several ports write the same address in one cycle, the highest-index port SHALL win; lower-index ports to that address are discarded.
REQ-023 With BYPASS=1, a read SHALL return the winning same-cycle write data for its address (including the OVF_REG bit-0 merge); with BYPASS=0 it SHALL return the stored value.
REQ-024 iss_valid=1 SHALL set busy_vec[iss_addr] at the next edge.
REQ-025 Any wr_en=1 to an address, overflowed or not, SHALL clear that busy bit at the next edge.
REQ-026 Issue and write to the same address in one cycle SHALL leave the busy bit set (new producer wins).
REQ-027 rd_busy[i] SHALL equal busy_vec[rd_addr_i] with the same-cycle clear/set rules of REQ-025..026 applied when BYPASS=1, and the registered value when BYPASS=0.
REQ-028 ovf_pulse SHALL be 1 in the cycle after at least one port presented wr_en=1 with wr_ovf=1 and addr!=0, and 0 otherwise.

Reset
REQ-029 While reset=1 at an edge, all registers, busy_vec and ovf_pulse SHALL clear to 0; writes and issues in that cycle are dropped.
REQ-030 Reset asserted mid-sequence SHALL discard pending busy bits; the first edge after deassertion behaves normally.

Structure
REQ-031 A shared package SHALL hold the default width/depth constants, the OVF_REG default and the port-slice helper functions.
REQ-032 The write-priority resolver (per-register winner select and data mux) SHALL be one sub-module, gpr_wr_arbiter, used for both state update and bypass.

Verification
REQ-033 Reset, then write 0xDEADBEEF to r5 on port 0 -> next cycle rd r5 = 0xDEADBEEF, rd_neg=1.
REQ-034 Ports 0 and 1 both write r7 (0x1, 0x2) same cycle -> r7 = 0x2; with BYPASS=1, same-cycle read of r7 = 0x2.
REQ-035 r30 = 0x10, overflowed write to r9 -> r9 unchanged, r30 = 0x11, ovf_pulse=1 for exactly one cycle.
REQ-036 Issue r4, then 3 idle cycles -> rd_busy=1 throughout; write r4 together with a new issue of r4 -> busy stays 1; a later plain write -> busy 0.
REQ-037 Write r0 = 0xFFFF_FFFF and issue r0 -> r0 reads 0, busy_vec[0]=0.
REQ-038 Assert reset one cycle after issuing r3 and writing r3 -> r3 = 0, busy_vec all zero, ovf_pulse=0.
